// File: rtl/prog_loader.sv
// prog_loader: parses a framed byte stream (A5, count, count x 4 bytes MSB first) into 32-bit
// instruction-memory writes, holding the core in reset until the load completes.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte over the data bytes.
module prog_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              err
);

    localparam logic [7:0]  MAGIC = 8'hA5;
    localparam int unsigned CNT_W = 16;
    // One extra index bit so that count == 2**ADDR_W terminates without wrapping
    localparam int unsigned IDX_W = ADDR_W + 1;
    localparam int unsigned CMP_W = (IDX_W > CNT_W + 1) ? IDX_W : CNT_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERR
    } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = CHK;
`else
    localparam state_t AFTER_DATA = DONE;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]        nbyte_q, nbyte_d;
    logic [31:0]       asm_q, asm_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic              rx_ready_d, im_we_d, core_rst_d, done_d, err_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       wdata_d;

    logic              accept;
    logic [CNT_W-1:0]  len;
    logic [31:0]       word;
    logic [IDX_W-1:0]  idx_inc;

    assign accept  = rx_valid & rx_ready;
    assign len     = {count_q[CNT_W-1:8], rx_data};
    assign word    = {asm_q[23:0], rx_data};
    assign idx_inc = idx_q + IDX_W'(1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state, datapath and registered-output next values
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        nbyte_d    = nbyte_q;
        asm_d      = asm_q;
        addr_d     = im_addr;
        wdata_d    = im_wdata;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        rx_ready_d = 1'b1;
        im_we_d    = 1'b0;
        core_rst_d = 1'b1;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE, DONE, ERR: begin
                // Only the magic byte starts a load; anything else is dropped
                if (accept && rx_data == MAGIC) begin
                    state_d = LEN_HI;
                    count_d = '0;
                    idx_d   = '0;
                    nbyte_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            LEN_HI: begin
                if (accept) begin
                    count_d = {rx_data, 8'h00};
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    count_d = len;
                    if (CMP_W'(len) > CMP_W'(MAX_WORDS)) state_d = ERR;
                    else if (len == '0)                  state_d = AFTER_DATA;
                    else                                 state_d = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    asm_d   = word;
                    nbyte_d = nbyte_q + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ rx_data;
`endif
                    if (nbyte_q == 2'd3) begin
                        state_d = WRITE;
                        addr_d  = ADDR_W'(idx_q);
                        wdata_d = word;
                    end
                end
            end
            WRITE: begin
                idx_d   = idx_inc;
                state_d = (CMP_W'(idx_inc) == CMP_W'(count_q)) ? AFTER_DATA : DATA;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) state_d = (rx_data == csum_q) ? DONE : ERR;
            end
`endif
            default: state_d = IDLE;
        endcase

        // Status outputs follow the state being entered so they register in step with it
        rx_ready_d = (state_d != WRITE);
        im_we_d    = (state_d == WRITE);
        core_rst_d = (state_d != DONE);
        done_d     = (state_d == DONE);
        err_d      = (state_d == ERR);
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            idx_q    <= '0;
            nbyte_q  <= '0;
            asm_q    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
            rx_ready <= 1'b1;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
            core_rst <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            count_q  <= count_d;
            idx_q    <= idx_d;
            nbyte_q  <= nbyte_d;
            asm_q    <= asm_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
            rx_ready <= rx_ready_d;
            im_we    <= im_we_d;
            im_addr  <= addr_d;
            im_wdata <= wdata_d;
            core_rst <= core_rst_d;
            done     <= done_d;
            err      <= err_d;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: random and directed frames checked against a frame-level model of the loader
// (expected write list, expected final status) with per-cycle output checks.
module tb_prog_loader;

    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned MAX_WORDS = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              core_rst;
    logic              done;
    logic              err;

    int          vectors     = 0;
    int          miscompares = 0;
    bit          stuck       = 1'b0;
    int          we_req      = 0;
    int          we_ack      = 0;
    int          wr_count    = 0;
    int          last_addr   = -1;
    logic [31:0] last_data   = '0;
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] word_src[$];

    prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .core_rst (core_rst),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle checks; writes are matched against the expected write list in order
    task automatic cycle_check();
        bit          due;
        int          a;
        logic [31:0] d;
        due    = (we_req != we_ack);
        we_ack = we_req;
        cmp("done_err_exclusive", 32'(done & err), 32'd0);
        cmp("core_rst_vs_done", 32'(core_rst), 32'(!done));
        cmp("rx_ready_in_write", 32'(rx_ready), 32'(!im_we));
        cmp("im_we_timing", 32'(im_we), 32'(due));
        if (im_we === 1'b1) begin
            wr_count++;
            if (exp_addr.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                         im_addr, im_wdata);
            end else begin
                a = exp_addr.pop_front();
                d = exp_data.pop_front();
                cmp("im_addr", 32'(im_addr), 32'(a));
                cmp("im_wdata", im_wdata, d);
                last_addr = int'(im_addr);
                last_data = im_wdata;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        cmp({tag, "_core_rst"}, 32'(core_rst), 32'd1);
        cmp({tag, "_done"},     32'(done),     32'd0);
        cmp({tag, "_err"},      32'(err),      32'd0);
        cmp({tag, "_im_we"},    32'(im_we),    32'd0);
        cmp({tag, "_im_addr"},  32'(im_addr),  32'd0);
        cmp({tag, "_im_wdata"}, im_wdata,      32'd0);
        cmp({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
    endtask

    // Present one byte and hold it until accepted; word_end marks the 4th byte of a word
    task automatic send_byte(input logic [7:0] b, input bit word_end);
        bit acc;
        int waited;
        int idle;
        if (stuck) return;
        idle = int'($urandom_range(0, 3));
        if (idle < 2) idle = 0;
        repeat (idle) @(negedge clk);
        acc    = 1'b0;
        waited = 0;
        while (!acc) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = b;
            acc      = rx_ready;
            @(posedge clk);
            waited++;
            if (!acc && waited > 40) begin
                vectors++;
                miscompares++;
                $display("FAIL handshake_timeout: got rx_ready=0 for %0d cycles, required acceptance", waited);
                stuck = 1'b1;
                #1 rx_valid = 1'b0;
                return;
            end
        end
        if (word_end) we_req++;
        #1 rx_valid = 1'b0;
    endtask

    task automatic check_status(input string tag, input bit exp_done, input bit exp_err);
        repeat (3) @(negedge clk);
        cmp({tag, "_done"},     32'(done),     32'(exp_done));
        cmp({tag, "_err"},      32'(err),      32'(exp_err));
        cmp({tag, "_core_rst"}, 32'(core_rst), 32'(!exp_done));
        cmp({tag, "_pending"},  32'(exp_addr.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_values("midframe_reset");
        exp_addr.delete();
        exp_data.delete();
        we_ack = we_req;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Send one frame and predict its writes and final status; abort_at >= 0 resets the DUT
    // before that data byte index is sent
    task automatic run_frame(input int n_junk, input int cnt, input bit bad, input int abort_at);
        logic [31:0] w;
        logic [7:0]  x;
        logic [7:0]  b;
        x = '0;
        for (int i = 0; i < n_junk; i++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5A;
            send_byte(b, 1'b0);
        end
        send_byte(8'hA5, 1'b0);
        send_byte(8'(cnt >> 8), 1'b0);
        send_byte(8'(cnt), 1'b0);
        if (cnt > int'(MAX_WORDS)) begin
            cmp("oversize_err_next_cycle", 32'(err), 32'd1);
            cmp("oversize_no_we", 32'(im_we), 32'd0);
            check_status("oversize", 1'b0, 1'b1);
            return;
        end
        for (int i = 0; i < cnt; i++) begin
            w = (word_src.size() != 0) ? word_src.pop_front() : $urandom;
            exp_addr.push_back(i);
            exp_data.push_back(w);
            for (int j = 0; j < 4; j++) begin
                if (i * 4 + j == abort_at) begin
                    do_reset();
                    return;
                end
                b = w[31 - 8 * j -: 8];
                x = x ^ b;
                send_byte(b, j == 3);
            end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(bad ? (x ^ 8'h01) : x, 1'b0);
        check_status("frame", !bad, bad);
`else
        check_status("frame", 1'b1, bad);
`endif
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        fork
            forever begin
                @(negedge clk);
                cycle_check();
            end
            begin
                int base;
                int cnt;
                int abort_at;
                bit bad;
                repeat (2) @(negedge clk);
                check_reset_values("reset");
                rst = 1'b0;

                // Single word 0x12345678 at address 0
                base = wr_count;
                word_src.push_back(32'h12345678);
                run_frame(0, 1, 1'b0, -1);
                cmp("one_word_writes", 32'(wr_count - base), 32'd1);
                cmp("one_word_addr", 32'(last_addr), 32'd0);
                cmp("one_word_data", last_data, 32'h12345678);

                // Leading junk ignored, two words
                base = wr_count;
                send_byte(8'h00, 1'b0);
                send_byte(8'hFF, 1'b0);
                run_frame(0, 2, 1'b0, -1);
                cmp("two_word_writes", 32'(wr_count - base), 32'd2);
                cmp("two_word_last_addr", 32'(last_addr), 32'd1);

`ifdef PROG_LOADER_CHECKSUM_EN
                // Bad checksum then recovery
                word_src.push_back(32'h00000001);
                run_frame(0, 1, 1'b1, -1);
                run_frame(0, 3, 1'b0, -1);
`endif

                // Oversize count 1025
                base = wr_count;
                run_frame(0, int'(MAX_WORDS) + 1, 1'b0, -1);
                cmp("oversize_writes", 32'(wr_count - base), 32'd0);

                // Reset after two data bytes, then a clean reload
                run_frame(0, 2, 1'b0, 2);
                base = wr_count;
                word_src.push_back(32'hDEADBEEF);
                run_frame(0, 1, 1'b0, -1);
                cmp("after_reset_writes", 32'(wr_count - base), 32'd1);
                cmp("after_reset_addr", 32'(last_addr), 32'd0);
                cmp("after_reset_data", last_data, 32'hDEADBEEF);

                // Zero-length frame
                base = wr_count;
                run_frame(0, 0, 1'b0, -1);
                cmp("zero_len_writes", 32'(wr_count - base), 32'd0);

                // Random frames
                for (int k = 0; k < 30; k++) begin
                    if ($urandom_range(0, 7) == 0) cnt = int'(MAX_WORDS) + 1 + int'($urandom_range(0, 200));
                    else                           cnt = int'($urandom_range(0, 6));
`ifdef PROG_LOADER_CHECKSUM_EN
                    bad = ($urandom_range(0, 3) == 0);
`else
                    bad = 1'b0;
`endif
                    abort_at = -1;
                    if (cnt > 0 && cnt <= int'(MAX_WORDS) && $urandom_range(0, 7) == 0)
                        abort_at = int'($urandom_range(0, 32'(cnt * 4 - 1)));
                    run_frame(int'($urandom_range(0, 3)), cnt, bad, abort_at);
                end

                // Largest legal program
                base = wr_count;
                run_frame(0, int'(MAX_WORDS), 1'b0, -1);
                cmp("max_len_writes", 32'(wr_count - base), 32'(MAX_WORDS));
                cmp("max_len_last_addr", 32'(last_addr), 32'(MAX_WORDS - 1));

                repeat (2) @(negedge clk);
                $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
                $finish;
            end
        join
    end

endmodule
